// File: rtl/lut_config_loader.sv
// Configuration sequencer for an array of fractured LUTs on a shared config bus.
// Assembles one MEM_SIZE-bit image per LUT from a word stream, then pulses that LUT's cen.
module lut_config_loader #(
  parameter  int INPUTS   = 4,
  parameter  int NUM_LUTS = 4,
  parameter  int WORD_W   = 8,
  localparam int MEM_SIZE = 2 ** INPUTS,
  localparam int WPL      = MEM_SIZE / WORD_W,
  localparam int LIDX_W   = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1,
  localparam int WC_W     = $clog2(WPL) + 1
) (
  input  logic                cclk,
  input  logic                crst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [WORD_W-1:0]   din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic [MEM_SIZE-1:0] config_out,
  output logic [NUM_LUTS-1:0] cen,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [LIDX_W-1:0]   lut_idx;
  logic [WC_W-1:0]     word_cnt;
  logic [MEM_SIZE-1:0] shadow, shadow_nxt;
  logic                accept, last_word, last_lut, err_q;

  // Abort beats a coincident final-word accept, so a dropped word never reaches COMMIT.
  assign accept    = (state == S_LOAD) && din_valid && !abort;
  assign last_word = (word_cnt == WC_W'(WPL - 1));
  assign last_lut  = (lut_idx == LIDX_W'(NUM_LUTS - 1));

  generate
    if (WPL == 1) begin : g_single
      assign shadow_nxt = din;
    end else begin : g_shift
      assign shadow_nxt = {shadow[MEM_SIZE-WORD_W-1:0], din};
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge cclk or negedge crst_n) begin
    if (!crst_n) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:   if (start) state_nxt = S_LOAD;
        S_LOAD:   if (accept && last_word) state_nxt = S_COMMIT;
        S_COMMIT: state_nxt = last_lut ? S_DONE : S_LOAD;
        S_DONE:   state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // A cen pulse is decoded from registered COMMIT, so an abort in that cycle cannot cancel it.
  always_comb begin
    din_ready = (state == S_LOAD);
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    err       = err_q;
    cen       = '0;
    if (state == S_COMMIT) cen[lut_idx] = 1'b1;
  end

  always_ff @(posedge cclk or negedge crst_n) begin
    if (!crst_n) begin
      lut_idx    <= '0;
      word_cnt   <= '0;
      shadow     <= '0;
      config_out <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= start && !abort && (state != S_IDLE);
      if (abort) begin
        lut_idx  <= '0;
        word_cnt <= '0;
      end else begin
        unique case (state)
          S_IDLE: if (start) begin
            lut_idx  <= '0;
            word_cnt <= '0;
          end
          S_LOAD: if (accept) begin
            shadow   <= shadow_nxt;
            word_cnt <= last_word ? '0 : word_cnt + 1'b1;
            // Image goes out on the edge entering COMMIT and holds until the next COMMIT.
            if (last_word) config_out <= shadow_nxt;
          end
          S_COMMIT: if (!last_lut) lut_idx <= lut_idx + 1'b1;
          S_DONE:   lut_idx <= '0;
          default:  lut_idx <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lut_config_loader.sv
// Directed bench for lut_config_loader: a 2-LUT/8-bit instance driven from a vector table,
// plus hand sequences for async reset and a 1-LUT/16-bit (one word per image) instance.
module tb_lut_config_loader;

  logic cclk = 1'b0;
  logic crst_n = 1'b0;
  always #5 cclk = ~cclk;

  logic        a_start = 0, a_abort = 0, a_din_valid = 0;
  logic [7:0]  a_din = '0;
  logic        a_din_ready, a_busy, a_done, a_err;
  logic [15:0] a_config_out;
  logic [1:0]  a_cen;

  logic        b_start = 0, b_abort = 0, b_din_valid = 0;
  logic [15:0] b_din = '0;
  logic        b_din_ready, b_busy, b_done, b_err;
  logic [15:0] b_config_out;
  logic [0:0]  b_cen;

  lut_config_loader #(.INPUTS(4), .NUM_LUTS(2), .WORD_W(8)) u_a (
    .cclk(cclk), .crst_n(crst_n), .start(a_start), .abort(a_abort), .din(a_din),
    .din_valid(a_din_valid), .din_ready(a_din_ready), .config_out(a_config_out),
    .cen(a_cen), .busy(a_busy), .done(a_done), .err(a_err));

  lut_config_loader #(.INPUTS(4), .NUM_LUTS(1), .WORD_W(16)) u_b (
    .cclk(cclk), .crst_n(crst_n), .start(b_start), .abort(b_abort), .din(b_din),
    .din_valid(b_din_valid), .din_ready(b_din_ready), .config_out(b_config_out),
    .cen(b_cen), .busy(b_busy), .done(b_done), .err(b_err));

  typedef struct {
    logic        st, ab, vl;
    logic [7:0]  d;
    logic        rdy;
    logic [1:0]  cen;
    logic [15:0] cfg;
    logic        busy, done, err;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Row = inputs driven this cycle + outputs expected in this same cycle.
  task automatic v(input logic st, ab, vl, input logic [7:0] d, input logic rdy,
                   input logic [1:0] c, input logic [15:0] cfg, input logic b, dn, e);
    vecs.push_back('{st: st, ab: ab, vl: vl, d: d, rdy: rdy, cen: c, cfg: cfg,
                     busy: b, done: dn, err: e});
  endtask

  task automatic check_a_all(input string tag, input logic rdy, input logic [1:0] c,
                             input logic [15:0] cfg, input logic b, dn, e);
    check({tag, " ready"}, a_din_ready, rdy);
    check({tag, " cen"},   a_cen, c);
    check({tag, " cfg"},   a_config_out, cfg);
    check({tag, " busy"},  a_busy, b);
    check({tag, " done"},  a_done, dn);
    check({tag, " err"},   a_err, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Back-to-back stream into two LUTs.
    v(1,0,0,8'h00, 0,2'b00,16'h0000,0,0,0);
    v(0,0,1,8'hAB, 1,2'b00,16'h0000,1,0,0);
    v(0,0,1,8'hCD, 1,2'b00,16'h0000,1,0,0);
    v(0,0,0,8'h00, 0,2'b01,16'hABCD,1,0,0);
    v(0,0,1,8'h12, 1,2'b00,16'hABCD,1,0,0);
    v(0,0,1,8'h34, 1,2'b00,16'hABCD,1,0,0);
    v(0,0,0,8'h00, 0,2'b10,16'h1234,1,0,0);
    v(0,0,0,8'h00, 0,2'b00,16'h1234,1,1,0);
    v(0,0,0,8'h00, 0,2'b00,16'h1234,0,0,0);
    // Same stream with 3-cycle din_valid gaps.
    v(1,0,0,8'h00, 0,2'b00,16'h1234,0,0,0);
    v(0,0,1,8'hAB, 1,2'b00,16'h1234,1,0,0);
    for (int i = 0; i < 3; i++) v(0,0,0,8'h00, 1,2'b00,16'h1234,1,0,0);
    v(0,0,1,8'hCD, 1,2'b00,16'h1234,1,0,0);
    v(0,0,0,8'h00, 0,2'b01,16'hABCD,1,0,0);
    for (int i = 0; i < 3; i++) v(0,0,0,8'h00, 1,2'b00,16'hABCD,1,0,0);
    v(0,0,1,8'h12, 1,2'b00,16'hABCD,1,0,0);
    for (int i = 0; i < 3; i++) v(0,0,0,8'h00, 1,2'b00,16'hABCD,1,0,0);
    v(0,0,1,8'h34, 1,2'b00,16'hABCD,1,0,0);
    v(0,0,0,8'h00, 0,2'b10,16'h1234,1,0,0);
    v(0,0,0,8'h00, 0,2'b00,16'h1234,1,1,0);
    v(0,0,0,8'h00, 0,2'b00,16'h1234,0,0,0);
    // Abort coinciding with the final word of LUT 0, then a fresh run from LUT 0.
    v(1,0,0,8'h00, 0,2'b00,16'h1234,0,0,0);
    v(0,0,1,8'hAB, 1,2'b00,16'h1234,1,0,0);
    v(0,1,1,8'hCD, 1,2'b00,16'h1234,1,0,0);
    v(0,0,0,8'h00, 0,2'b00,16'h1234,0,0,0);
    v(1,0,0,8'h00, 0,2'b00,16'h1234,0,0,0);
    v(0,0,1,8'h11, 1,2'b00,16'h1234,1,0,0);
    v(0,0,1,8'h22, 1,2'b00,16'h1234,1,0,0);
    v(0,0,0,8'h00, 0,2'b01,16'h1122,1,0,0);
    v(0,0,1,8'h33, 1,2'b00,16'h1122,1,0,0);
    v(0,0,1,8'h44, 1,2'b00,16'h1122,1,0,0);
    v(0,0,0,8'h00, 0,2'b10,16'h3344,1,0,0);
    v(0,0,0,8'h00, 0,2'b00,16'h3344,1,1,0);
    v(0,0,0,8'h00, 0,2'b00,16'h3344,0,0,0);
    // Abort during COMMIT: the pulse still fires, then straight to IDLE with no done.
    v(1,0,0,8'h00, 0,2'b00,16'h3344,0,0,0);
    v(0,0,1,8'h55, 1,2'b00,16'h3344,1,0,0);
    v(0,0,1,8'h66, 1,2'b00,16'h3344,1,0,0);
    v(0,1,0,8'h00, 0,2'b01,16'h5566,1,0,0);
    v(0,0,0,8'h00, 0,2'b00,16'h5566,0,0,0);
    v(0,0,0,8'h00, 0,2'b00,16'h5566,0,0,0);
    // Start while busy (LOAD and DONE) -> err next cycle; abort+start in IDLE -> nothing.
    v(1,0,0,8'h00, 0,2'b00,16'h5566,0,0,0);
    v(1,0,1,8'h77, 1,2'b00,16'h5566,1,0,0);
    v(0,0,1,8'h88, 1,2'b00,16'h5566,1,0,1);
    v(0,0,0,8'h00, 0,2'b01,16'h7788,1,0,0);
    v(0,0,1,8'h99, 1,2'b00,16'h7788,1,0,0);
    v(0,0,1,8'hAA, 1,2'b00,16'h7788,1,0,0);
    v(0,0,0,8'h00, 0,2'b10,16'h99AA,1,0,0);
    v(1,0,0,8'h00, 0,2'b00,16'h99AA,1,1,0);
    v(1,1,0,8'h00, 0,2'b00,16'h99AA,0,0,1);
    v(0,0,0,8'h00, 0,2'b00,16'h99AA,0,0,0);
    v(0,0,0,8'h00, 0,2'b00,16'h99AA,0,0,0);

    // Reset state.
    #2;
    check_a_all("reset", 0, 2'b00, 16'h0000, 0, 0, 0);
    check("reset b busy", b_busy, 1'b0);
    check("reset b cen", b_cen, 1'b0);
    #10 crst_n = 1'b1;
    @(posedge cclk); #1;

    foreach (vecs[i]) begin
      a_start = vecs[i].st; a_abort = vecs[i].ab;
      a_din_valid = vecs[i].vl; a_din = vecs[i].d;
      @(negedge cclk);
      check_a_all($sformatf("v%0d", i), vecs[i].rdy, vecs[i].cen, vecs[i].cfg,
                  vecs[i].busy, vecs[i].done, vecs[i].err);
      @(posedge cclk); #1;
    end
    a_start = 0; a_abort = 0; a_din_valid = 0; a_din = '0;

    // Async reset after three accepted words (mid-LUT 1).
    a_start = 1;                     @(posedge cclk); #1;
    a_start = 0; a_din_valid = 1; a_din = 8'hAB; @(posedge cclk); #1;
    a_din = 8'hCD;                   @(posedge cclk); #1;
    a_din_valid = 0;                 @(posedge cclk); #1;
    a_din_valid = 1; a_din = 8'h12;  @(posedge cclk); #1;
    a_din_valid = 0;
    check("pre-rst busy", a_busy, 1'b1);
    check("pre-rst cfg", a_config_out, 16'hABCD);
    #2 crst_n = 1'b0;
    #1 check_a_all("async-rst", 0, 2'b00, 16'h0000, 0, 0, 0);
    #3 crst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge cclk);
      check_a_all($sformatf("post-rst%0d", i), 0, 2'b00, 16'h0000, 0, 0, 0);
    end

    // One word per image, single LUT.
    @(posedge cclk); #1;
    b_start = 1;                     @(posedge cclk); #1;
    b_start = 0;
    check("b load ready", b_din_ready, 1'b1);
    check("b load busy", b_busy, 1'b1);
    b_din_valid = 1; b_din = 16'hBEEF; @(posedge cclk); #1;
    b_din_valid = 0;
    check("b commit cen", b_cen, 1'b1);
    check("b commit cfg", b_config_out, 16'hBEEF);
    check("b commit ready", b_din_ready, 1'b0);
    check("b commit done", b_done, 1'b0);
    @(posedge cclk); #1;
    check("b done pulse", b_done, 1'b1);
    check("b done cen", b_cen, 1'b0);
    @(posedge cclk); #1;
    check("b idle busy", b_busy, 1'b0);
    check("b idle done", b_done, 1'b0);
    check("b idle cfg", b_config_out, 16'hBEEF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
